// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT/MULTU commit after MULT_CYCLES, DIV/DIVU after DIV_CYCLES; MT*/MF* take effect in one cycle.
// Backpressure: busy stalls dependent D-stage ops; mul/div/MT ops presented while busy are dropped.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  op,
    input  logic        req,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CW-1:0] countdown;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic is_mul, is_div, is_md, idle, start, mt_wr;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_md  = is_mul || is_div;
    assign idle   = (countdown == '0);
    assign start  = is_md && !req && idle;
    assign mt_wr  = ((op == OP_MTHI) || (op == OP_MTLO)) && !req && idle;
    assign busy   = (is_md && !req) || !idle;

    // One 64x64 multiplier serves both flavours; only the operand extension differs.
    logic        mul_sgn;
    logic [63:0] a_ext, b_ext, prod;
    assign mul_sgn = (op == OP_MULT);
    assign a_ext   = {{32{mul_sgn & a[31]}}, a};
    assign b_ext   = {{32{mul_sgn & b[31]}}, b};
    assign prod    = a_ext * b_ext;

    // Signed divide is done on magnitudes so truncation and remainder sign are explicit;
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    logic        div_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;
    assign div_sgn = (op == OP_DIV);
    assign a_neg   = div_sgn & a[31];
    assign b_neg   = div_sgn & b[31];
    assign a_mag   = a_neg ? (32'd0 - a) : a;
    assign b_mag   = b_neg ? (32'd0 - b) : b;
    assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq      = a_mag / b_safe;
    assign ur      = a_mag % b_safe;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem     = a_neg ? (32'd0 - ur) : ur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            countdown <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_wr   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (start) begin
                countdown <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                if (is_mul) begin
                    {pend_hi, pend_lo} <= prod;
                end else begin
                    {pend_hi, pend_lo} <= {rem, quot};
                end
                pend_wr <= is_mul || (b != 32'd0);
            end else if (!idle) begin
                countdown <= countdown - CW'(1);
                if ((countdown == CW'(1)) && pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
            if (mt_wr) begin
                if (op == OP_MTHI) begin
                    hi <= a;
                end else begin
                    lo <= a;
                end
            end
        end
    end

    always_comb begin
        result = '0;
        case (op)
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  op = 4'd0;
    logic        req = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .req(req), .a(a), .b(b),
        .busy(busy), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv, input logic r);
        op = o; a = av; b = bv; req = r;
        #1;
    endtask

    task automatic tick_idle();
        @(posedge clk); #1;
        op = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
        #1;
    endtask

    // Counts cycles with busy high starting from the current cycle, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick_idle();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int n;
        drive(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start: got %b want 1", busy); end
        count_busy(n);
        checks++; if (n != 6) begin errors++; $display("FAIL mult_busy_len: got %0d want 6", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi_after_mult: got %h want ffffffff", result); end
    endtask

    task automatic test_multu();
        drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        tick_idle();
        repeat (4) tick_idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_last: got %b want 1", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL multu_hi_precommit: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo_precommit: got %h want fffffffa", lo); end
        tick_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_end: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        int n;
        drive(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        count_busy(n);
        checks++; if (n != 11) begin errors++; $display("FAIL div_busy_len: got %0d want 11", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        drive(4'd4, 32'd7, 32'd0, 1'b0);
        count_busy(n);
        checks++; if (n != 11) begin errors++; $display("FAIL divu0_busy_len: got %0d want 11", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divu0_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_hi: got %h want ffffffff", hi); end
        drive(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        count_busy(n);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        drive(4'd4, 32'd100, 32'd7, 1'b0);
        count_busy(n);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", hi); end
    endtask

    task automatic test_ignore_while_busy();
        int n;
        drive(4'd1, 32'd3, 32'd4, 1'b0);
        tick_idle();
        tick_idle();
        drive(4'd3, 32'd100, 32'd7, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_div: got %b want 1", busy); end
        @(posedge clk); #1;
        drive(4'd8, 32'h1234, 32'd0, 1'b0);
        tick_idle();
        count_busy(n);
        checks++; if (n != 2) begin errors++; $display("FAIL ignore_busy_tail: got %0d want 2", n); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL ignore_lo: got %h want c", lo); end
    endtask

    task automatic test_req();
        int n;
        drive(4'd1, 32'd5, 32'd5, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_mult_busy: got %b want 0", busy); end
        tick_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_mult_nostart: got %b want 0", busy); end
        drive(4'd7, 32'hAAAA, 32'd0, 1'b1);
        tick_idle();
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL req_mthi: got %h want 0", hi); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL req_lo_kept: got %h want c", lo); end
        drive(4'd4, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        drive(4'd3, 32'd1, 32'd1, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL req_inflight_busy: got %b want 1", busy); end
        count_busy(n);
        checks++; if (n != 10) begin errors++; $display("FAIL req_inflight_len: got %0d want 10", n); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL req_inflight_lo: got %h want e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL req_inflight_hi: got %h want 2", hi); end
    endtask

    task automatic test_reset_mid();
        drive(4'd1, 32'd2, 32'd3, 1'b0);
        tick_idle();
        tick_idle();
        tick_idle();
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        #1 reset_n = 1'b1;
        repeat (8) tick_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_no_commit: got %h want 0", lo); end
    endtask

    task automatic test_mt_mf();
        drive(4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        checks++; if (result !== 32'hDEADBEEF) begin errors++; $display("FAIL mfhi: got %h want deadbeef", result); end
        drive(4'd8, 32'h1234, 32'd0, 1'b0);
        @(posedge clk); #1;
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        checks++; if (result !== 32'h1234) begin errors++; $display("FAIL mflo: got %h want 1234", result); end
        drive(4'd12, 32'd0, 32'd0, 1'b0);
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL result_other_op: got %h want 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_other_op: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_ignore_while_busy();
        test_req();
        test_reset_mid();
        test_mt_mf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
